// File: rtl/output_writeback_pkg.sv
// Shared types and width helpers for the output write-back block.
// Optional feature macro: OUTPUT_WRITEBACK_RELU_EN (clamps negative beats to zero at push).
package output_writeback_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } wb_state_e;

    // Index width for a range 0..n-1, never narrower than one bit.
    function automatic int wb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flat output-memory address width for a W x H x C feature map.
    function automatic int wb_addr_width(input int w, input int h, input int c);
        return wb_idx_width(w * h * c);
    endfunction

    // Default geometry of the accelerator output map.
    localparam int WB_DEF_DATA_WIDTH = 16;
    localparam int WB_DEF_WIDTH      = 128;
    localparam int WB_DEF_HEIGHT     = 128;
    localparam int WB_DEF_CHANNELS   = 2;
    localparam int WB_DEF_ADDR_WIDTH = wb_addr_width(WB_DEF_WIDTH, WB_DEF_HEIGHT, WB_DEF_CHANNELS);

    // One buffered beat at the default geometry: flat address plus data.
    typedef struct packed {
        logic [WB_DEF_ADDR_WIDTH-1:0] addr;
        logic [WB_DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/output_writeback_fifo.sv
// Synchronous FIFO of write-back entries with registered storage.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
// A push into a full FIFO is accepted when a pop happens in the same cycle; there is no
// empty-FIFO bypass, so a pushed entry becomes visible at the head one cycle later.
module writeback_fifo
    import output_writeback_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Status flags and the head entry straight from the pointers.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        head  = mem_q[rd_ptr_q[IW-1:0]];
    end

    // Qualify requests and advance the pointers.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage written at the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; equal pointers mark it empty and the top masks the head while empty.
        if (do_push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/output_writeback.sv
// Output write-back: buffers the accelerator output stream, maps (x,y,ch) to a flat
// address, writes each beat through a valid/ready memory port and counts one frame.
// Optional feature macro: OUTPUT_WRITEBACK_RELU_EN (negative data clamped to 0 at push).
module output_writeback
    import output_writeback_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 2,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [DATA_WIDTH-1:0]                         output_data,
    input  logic                                          output_valid,
    input  logic [wb_idx_width(FEATURE_MAP_WIDTH)-1:0]    output_x,
    input  logic [wb_idx_width(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    input  logic [wb_idx_width(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
    output logic                                          mem_we,
    input  logic                                          mem_ready,
    output logic [wb_addr_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]                         mem_wdata,
    output logic                                          busy,
    output logic                                          frame_done,
    output logic                                          overflow
);

    localparam int AW    = wb_addr_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
    localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

    // Buffered beat at this instance's geometry.
    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    wb_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    entry_t        push_entry;
    entry_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_accept;

    // Flat address and (optionally rectified) data of the incoming beat.
    always_comb begin
        push_entry.addr = (AW'(output_ch) * AW'(FEATURE_MAP_HEIGHT) + AW'(output_y))
                          * AW'(FEATURE_MAP_WIDTH) + AW'(output_x);
`ifdef OUTPUT_WRITEBACK_RELU_EN
        push_entry.data = output_data[DATA_WIDTH-1] ? '0 : output_data;
`else
        push_entry.data = output_data;
`endif
    end

    // Write handshake and push qualification; a full FIFO still takes a beat when it pops.
    always_comb begin
        pop         = !fifo_empty && mem_ready;
        push_accept = (state_q == COLLECT) && output_valid && (!fifo_full || pop);
    end

    writeback_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_accept),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Frame sequencing, accepted-beat counting and drop detection.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COLLECT;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            COLLECT: begin
                if (push_accept && (count_q != TOTAL_C)) begin
                    count_d = count_q + CW'(1);
                end
                if (output_valid && fifo_full && !pop) begin
                    overflow_d = 1'b1;
                end
                if (count_d == TOTAL_C) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (output_valid) begin
                    overflow_d = 1'b1;
                end
                // mem_we follows !empty, so an empty FIFO also means no write is pending.
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (output_valid) begin
                    overflow_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Output port view; head contents are masked while the FIFO is empty.
    always_comb begin
        mem_we     = !fifo_empty;
        mem_addr   = fifo_empty ? '0 : head.addr;
        mem_wdata  = fifo_empty ? '0 : head.data;
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback at W=4, H=2, C=2, FIFO depth 4.
// Inputs are driven 1 ns after the rising edge; checks read outputs at that same point,
// and a monitor logs every write handshake and frame_done pulse on the falling edge.
module tb_output_writeback;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int C  = 2;
    localparam int D  = 4;

`ifdef OUTPUT_WRITEBACK_RELU_EN
    localparam logic [DW-1:0] NEG_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] NEG_EXP = 16'hFFFB;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] output_data;
    logic          output_valid;
    logic [1:0]    output_x;
    logic [0:0]    output_y;
    logic [0:0]    output_ch;
    logic          mem_we;
    logic          mem_ready;
    logic [3:0]    mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    int            cyc_n = 0;
    int            last_wr_cyc = 0;
    int            fd_count = 0;
    int            fd_cyc = 0;
    logic [3:0]    wa [$];
    logic [DW-1:0] wd [$];

    output_writeback #(
        .DATA_WIDTH         (DW),
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .OUTPUT_NB_CHANNELS (C),
        .FIFO_DEPTH         (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_x     (output_x),
        .output_y     (output_y),
        .output_ch    (output_ch),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    // Log write handshakes and frame_done pulses.
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            last_wr_cyc = cyc_n;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=still running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        fd_count = 0;
    endtask

    // Beat index i in raster order: x fastest, then y, then ch; flat address equals i.
    task automatic set_beat(input int i, input logic [DW-1:0] data);
        output_valid = 1'b1;
        output_x     = 2'(i % 4);
        output_y     = 1'((i / 4) % 2);
        output_ch    = 1'(i / 8);
        output_data  = data;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        output_valid = 1'b0;
        mem_ready    = 1'b1;
        cyc();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic start_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [3:0] wa_at(input int i);
        return (i < wa.size()) ? wa[i] : 4'hx;
    endfunction

    function automatic logic [DW-1:0] wd_at(input int i);
        return (i < wd.size()) ? wd[i] : 16'hxxxx;
    endfunction

    // 16 back-to-back beats with mem_ready high, a stray start mid-frame, optional 17th beat.
    task automatic full_frame(input logic [DW-1:0] base, input logic extra);
        clear_mon();
        mem_ready = 1'b1;
        start_frame();
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            set_beat(i, base + DW'(i));
            start = (i == 8);
            cyc();
            if (i == 0) begin
                check("first_beat_we", mem_we, 1);
                check("first_beat_addr", mem_addr, 0);
            end
        end
        start = 1'b0;
        if (extra) begin
            set_beat(0, 16'hDEAD);
            cyc();
        end
        output_valid = 1'b0;
        for (int i = 0; i < 40 && fd_count == 0; i++) cyc();
        cyc(3);
        check("frame_writes", wa.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("frame_addr[%0d]", i), wa_at(i), i);
            check($sformatf("frame_data[%0d]", i), wd_at(i), base + DW'(i));
        end
        check("frame_done_pulses", fd_count, 1);
        // Last write handshake in cycle k, FIFO empty in k+1, DONE in k+2.
        check("frame_done_gap", fd_cyc - last_wr_cyc, 2);
        check("frame_overflow", overflow, extra);
        check("frame_busy_end", busy, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        output_valid = 1'b0;
        output_data  = '0;
        output_x     = '0;
        output_y     = '0;
        output_ch    = '0;
        mem_ready    = 1'b1;

        // Reset state.
        cyc();
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        cyc();
        clear_mon();

        // Clean frame, writes in raster order.
        full_frame(16'h0100, 1'b0);

        // Stall: 6 beats into a 4-deep FIFO with mem_ready low.
        do_reset();
        start_frame();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(i, 16'h0200 + DW'(i));
            cyc();
        end
        output_valid = 1'b0;
        check("stall_overflow", overflow, 1);
        check("stall_we", mem_we, 1);
        check("stall_addr", mem_addr, 0);
        check("stall_wdata", mem_wdata, 16'h0200);
        check("stall_no_writes", wa.size(), 0);
        cyc(2);
        check("stall_addr_held", mem_addr, 0);
        check("stall_wdata_held", mem_wdata, 16'h0200);
        mem_ready = 1'b1;
        cyc(8);
        check("stall_writes", wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_wr_addr[%0d]", i), wa_at(i), i);
            check($sformatf("stall_wr_data[%0d]", i), wd_at(i), 16'h0200 + i);
        end
        check("stall_we_drained", mem_we, 0);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        start_frame();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_beat(i, 16'h0300 + DW'(i));
            cyc();
        end
        check("full_no_overflow", overflow, 0);
        set_beat(4, 16'h0304);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        output_valid = 1'b0;
        check("pushpop_overflow", overflow, 0);
        check("pushpop_one_write", wa.size(), 1);
        check("pushpop_head", mem_addr, 1);
        // Occupancy is still 4: one more beat without a pop must be dropped.
        set_beat(5, 16'h0305);
        cyc();
        output_valid = 1'b0;
        check("still_full_drop", overflow, 1);
        mem_ready = 1'b1;
        cyc(8);
        check("pushpop_writes", wa.size(), 5);
        check("pushpop_addr1", wa_at(1), 1);
        check("pushpop_addr4", wa_at(4), 4);
        check("pushpop_data4", wd_at(4), 16'h0304);

        // Negative data path.
        do_reset();
        start_frame();
        set_beat(9, 16'hFFFB);
        cyc();
        output_valid = 1'b0;
        check("neg_we", mem_we, 1);
        check("neg_addr", mem_addr, 9);
        check("neg_wdata", mem_wdata, NEG_EXP);
        set_beat(10, 16'h7FFF);
        cyc();
        output_valid = 1'b0;
        cyc(3);
        check("neg_writes", wa.size(), 2);
        check("neg_wr_data", wd_at(0), NEG_EXP);
        check("pos_wr_addr", wa_at(1), 10);
        check("pos_wr_data", wd_at(1), 16'h7FFF);

        // Reset mid-frame with entries still buffered.
        do_reset();
        start_frame();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) mem_ready = 1'b0;
            set_beat(i, 16'h0400 + DW'(i));
            cyc();
        end
        output_valid = 1'b0;
        check("mid_writes", wa.size(), 4);
        check("mid_buffered", mem_addr, 4);
        rst = 1'b1;
        cyc();
        check("midrst_we", mem_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc(3);
        check("midrst_no_writes", wa.size(), 4);
        full_frame(16'h0500, 1'b0);

        // Beats while IDLE are ignored without a flag.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            set_beat(i, 16'h0700 + DW'(i));
            cyc();
        end
        output_valid = 1'b0;
        cyc(3);
        check("idle_no_writes", wa.size(), 0);
        check("idle_no_overflow", overflow, 0);
        check("idle_busy", busy, 0);
        check("idle_we", mem_we, 0);

        // 17th beat lands in DRAIN and is flagged.
        full_frame(16'h0600, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
